fb_mem_arbiter: RTL and testbench
=================================

Name: fb_mem_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM (24-bit words, 8 packed 3-bit pixels per word, pixel n in bits [3n+2:3n]) between two requesters:
  - the VGA scan-out word fetch;
  - a pixel draw port.
- Draw writes are done as read-modify-write so neighbouring pixels in the same word are preserved.
- Sits between the pixel-generation logic and the framebuffer RAM, upstream of the 3-bit pixel slot selector.

Parameters:
- WORDS, 38400, number of 24-bit words in the framebuffer (640x480/8).
- AW, 16, word address width; must satisfy 2**AW >= WORDS.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vid_req  in  1  scan-out word fetch request, single cycle, may assert every cycle
- vid_word_addr  in  AW  word to fetch
- vid_valid  out  1  one-cycle pulse, vid_data valid
- vid_data  out  24  fetched word
- drw_req  in  1  draw request, level; held with addr/pixel stable until drw_ack
- drw_addr  in  19  pixel address; word = [18:3], slot = [2:0]
- drw_pixel  in  3  pixel value
- drw_ack  out  1  one-cycle pulse, write issued or request dropped
- drw_busy  out  1  RMW in progress
- mem_en  out  1  RAM access strobe (registered)
- mem_we  out  1  write enable (registered)
- mem_addr  out  AW  RAM word address (registered)
- mem_wdata  out  24  RAM write data (registered)
- mem_rdata  in  24  RAM read data; valid the cycle after the RAM samples a read

Behaviour:
- One RAM operation per cycle. All mem_* outputs are registered; the arbitration decision is made at each clock edge.
- Priority, highest first: video read > draw write > draw read > clear write (optional feature).
- Video path:
  - vid_req sampled at edge N always issues a read at N.
  - vid_data is captured and vid_valid pulses after edge N+2. This fixed 2-cycle latency holds under all conflicts.
- A 2-deep read-tag shift register (VID / DRW / none) routes mem_rdata to its owner.
- Draw state machine:
  - IDLE: drw_req=1 and vid_req=0 -> issue read of drw_addr[18:3]; go to RD_WAIT; drw_busy=1.
  - Address out of range (drw_addr[18:3] >= WORDS) -> drw_ack pulse with no RAM access; stay in IDLE.
  - RD_WAIT -> CAPTURE, one cycle, unconditional.
  - CAPTURE: wbuf <= mem_rdata with slot drw_addr[2:0] replaced by drw_pixel; go to WR.
  - WR: at the first edge with vid_req=0, issue the write of wbuf, pulse drw_ack and return to IDLE (drw_busy=0). While vid_req is held, stay in WR.
  - IDLE with vid_req=1 -> stay in IDLE; the read is deferred.
- Latency with no conflict: req sampled at N, ack after N+3.
- Next draw accepted no earlier than the edge after ack.
- Hazard: a video read of the same word between RMW read and write returns pre-draw data. This is accepted; the display is correct on the next frame.
- drw_req deasserted before ack: behaviour undefined, so the bench must not do this.
- Reset (asynchronous, any state): FSM to IDLE; tags cleared; wbuf = 0.
  - All outputs reset to 0: vid_valid, vid_data, drw_ack, drw_busy, mem_en, mem_we, mem_addr, mem_wdata.
  - In-flight reads are discarded; no write and no ack are produced.

Optional Feature:
- Macro: FB_CLEAR_EN.
- Defined:
  - Adds ports clr_start (in, 1), clr_color (in, 3) and clr_busy (out, 1).
  - clr_start in IDLE latches clr_color, sets clr_busy and zeroes a word counter.
  - Each edge with no video read and no draw write in flight writes {8{color}} to the counter address, then increments the counter.
  - After writing word WORDS-1, clr_busy drops.
  - New draw requests are held off (stay in IDLE, no ack) while clr_busy=1.
  - clr_start while busy is ignored.
  - Reset clears clr_busy and the counter.
- Undefined: the ports are absent; the clear logic is absent.

Decomposition:
- Package fb_pkg:
  - FB_WORDS, FB_AW, PIX_W=3, PIX_PER_WORD=8;
  - draw state enum (IDLE, RD_WAIT, CAPTURE, WR);
  - read-tag enum (NONE, VID, DRW).
- Sub-module fb_pixel_merge: combinational insertion of 3-bit pixel into 24-bit word by slot. This is the inverse of the existing slot selector and is reused by future blit logic.

Test Plan:
- Reset: pulse reset_n low mid-stream -> all outputs 0 immediately; no mem_en after release until a request arrives.
- RAM word 5 = 0xFAC688; vid_req with addr 5 at edge N -> mem_en/addr 5 after N; vid_valid with vid_data=0xFAC688 after N+2.
- Word 5 = 0x000000; drw_req with addr 43, pixel 3'b101 -> read of word 5, then write of 0x000A00; drw_ack 3 cycles after req; word 5 reads back 0x000A00.
- Same draw with vid_req held high for 6 cycles starting in WR -> write deferred until vid_req drops; all 6 vid_valid arrive at 2-cycle latency with correct data; exactly one drw_ack.
- drw_addr=19'h7FFFF (out of range) -> drw_ack next cycle, no mem_we.
- FB_CLEAR_EN, clr_color=3'b011 -> every word = 0x6DB6DB; clr_busy high for >= WORDS cycles; a draw issued during clear is acked only after clr_busy falls. Reset asserted mid-RMW -> no write, no ack.

Source files
------------

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg : shared types and constants for the framebuffer arbiter  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package fb_pkg;

  localparam int FB_WORDS     = 38400;
  localparam int FB_AW        = 16;
  localparam int PIX_W        = 3;
  localparam int PIX_PER_WORD = 8;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    CAPTURE = 2'd2,
    WR      = 2'd3
  } drw_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    VID  = 2'd1,
    DRW  = 2'd2
  } rd_tag_e;

endpackage

`default_nettype wire

// File: rtl/fb_pixel_merge.sv
// ---------------------------------------------------------------------------
// fb_pixel_merge : insert one packed pixel into a framebuffer word  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fb_pixel_merge
  import fb_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [2:0]        slot_i,
  input  logic [PIX_W-1:0]  pixel_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    for (int n = 0; n < PIX_PER_WORD; n++) begin
      if (slot_i == 3'(n)) begin
        word_o[n*PIX_W +: PIX_W] = pixel_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// fb_mem_arbiter : video fetch / pixel RMW arbiter for the framebuffer RAM
// Optional FB_CLEAR_EN adds a full-screen clear engine.            (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fb_mem_arbiter
  import fb_pkg::*;
#(
  parameter int WORDS = FB_WORDS,
  parameter int AW    = FB_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [AW-1:0]     vid_word_addr,
  output logic              vid_valid,
  output logic [WORD_W-1:0] vid_data,
  input  logic              drw_req,
  input  logic [18:0]       drw_addr,
  input  logic [PIX_W-1:0]  drw_pixel,
  output logic              drw_ack,
  output logic              drw_busy,
`ifdef FB_CLEAR_EN
  input  logic              clr_start,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              clr_busy,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  drw_state_e        state_q;
  rd_tag_e           tag0_q, tag1_q;
  logic [WORD_W-1:0] wbuf_q, w_merged;
  logic              vid_valid_q, drw_ack_q, drw_busy_q;
  logic [WORD_W-1:0] vid_data_q, mem_wdata_q;
  logic              mem_en_q, mem_we_q;
  logic [AW-1:0]     mem_addr_q;

  logic [15:0] w_drw_word;
  logic        w_drw_oor, w_hold, w_drw_rd, w_drw_drop, w_drw_wr;

  assign w_drw_word = drw_addr[18:3];
  assign w_drw_oor  = (32'(w_drw_word) >= WORDS);

  // Video owns the port whenever it asks; every draw step yields to it.
  assign w_drw_rd   = (state_q == IDLE) && drw_req && !w_hold && !w_drw_oor && !vid_req;
  assign w_drw_drop = (state_q == IDLE) && drw_req && !w_hold && w_drw_oor;
  assign w_drw_wr   = (state_q == WR) && !vid_req;

  fb_pixel_merge u_merge (
    .word_i  (mem_rdata),
    .slot_i  (drw_addr[2:0]),
    .pixel_i (drw_pixel),
    .word_o  (w_merged)
  );

`ifdef FB_CLEAR_EN
  logic             clr_busy_q;
  logic [AW-1:0]    clr_cnt_q;
  logic [PIX_W-1:0] clr_color_q;
  logic             w_clr_go, w_clr_wr;

  assign w_clr_go = (state_q == IDLE) && clr_start && !clr_busy_q && !w_drw_rd && !w_drw_drop;
  assign w_clr_wr = clr_busy_q && !vid_req && !w_drw_wr;
  assign w_hold   = clr_busy_q;
  assign clr_busy = clr_busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_busy_q  <= 1'b0;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
    end else if (w_clr_go) begin
      clr_busy_q  <= 1'b1;
      clr_cnt_q   <= '0;
      clr_color_q <= clr_color;
    end else if (w_clr_wr) begin
      if (clr_cnt_q == AW'(WORDS - 1)) begin
        clr_busy_q <= 1'b0;
      end else begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
    end
  end
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tag0_q      <= NONE;
      tag1_q      <= NONE;
      wbuf_q      <= '0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      drw_ack_q   <= 1'b0;
      drw_busy_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      drw_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      tag0_q      <= NONE;
      tag1_q      <= tag0_q;

      // Read data belongs to whoever issued the read two edges ago.
      if (tag1_q == VID) begin
        vid_valid_q <= 1'b1;
        vid_data_q  <= mem_rdata;
      end

      if (vid_req) begin
        mem_en_q   <= 1'b1;
        mem_addr_q <= vid_word_addr;
        tag0_q     <= VID;
      end else if (w_drw_wr) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= AW'(w_drw_word);
        mem_wdata_q <= wbuf_q;
      end else if (w_drw_rd) begin
        mem_en_q   <= 1'b1;
        mem_addr_q <= AW'(w_drw_word);
        tag0_q     <= DRW;
      end
`ifdef FB_CLEAR_EN
      else if (w_clr_wr) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= clr_cnt_q;
        mem_wdata_q <= {PIX_PER_WORD{clr_color_q}};
      end
`endif

      case (state_q)
        IDLE: begin
          if (w_drw_rd) begin
            state_q    <= RD_WAIT;
            drw_busy_q <= 1'b1;
          end else if (w_drw_drop) begin
            drw_ack_q <= 1'b1;
          end
        end
        RD_WAIT: state_q <= CAPTURE;
        CAPTURE: begin
          wbuf_q  <= w_merged;
          state_q <= WR;
        end
        WR: begin
          if (!vid_req) begin
            drw_ack_q  <= 1'b1;
            drw_busy_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vid_valid = vid_valid_q;
  assign vid_data  = vid_data_q;
  assign drw_ack   = drw_ack_q;
  assign drw_busy  = drw_busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_mem_arbiter : self-checking bench with RAM model and shadow image
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fb_mem_arbiter;

  localparam int WORDS = 38400;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          vid_req;
  logic [AW-1:0] vid_word_addr;
  logic          vid_valid;
  logic [23:0]   vid_data;
  logic          drw_req;
  logic [18:0]   drw_addr;
  logic [2:0]    drw_pixel;
  logic          drw_ack, drw_busy;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata, mem_rdata;
`ifdef FB_CLEAR_EN
  logic          clr_start;
  logic [2:0]    clr_color;
  logic          clr_busy;
`endif

  logic          poke_en;
  logic [AW-1:0] poke_addr;
  logic [23:0]   poke_data;
  logic [23:0]   ram    [0:WORDS-1];
  logic [23:0]   shadow [0:WORDS-1];

  int total;
  int bad;

  always #5 clk = ~clk;

  fb_mem_arbiter #(.WORDS(WORDS), .AW(AW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .vid_req       (vid_req),
    .vid_word_addr (vid_word_addr),
    .vid_valid     (vid_valid),
    .vid_data      (vid_data),
    .drw_req       (drw_req),
    .drw_addr      (drw_addr),
    .drw_pixel     (drw_pixel),
    .drw_ack       (drw_ack),
    .drw_busy      (drw_busy),
`ifdef FB_CLEAR_EN
    .clr_start     (clr_start),
    .clr_color     (clr_color),
    .clr_busy      (clr_busy),
`endif
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Single-port synchronous RAM; pokes let the bench preload words.
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int addr, input logic [23:0] data);
    poke_en   = 1'b1;
    poke_addr = AW'(addr);
    poke_data = data;
    step();
    poke_en = 1'b0;
    shadow[addr] = data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    total++;
    if ({vid_valid, drw_ack, drw_busy, mem_en, mem_we} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {vid_valid, drw_ack, drw_busy, mem_en, mem_we});
    end
    total++;
    if ({vid_data, mem_addr, mem_wdata} !== 64'b0) begin
      bad++; $display("FAIL reset_data: got %h/%h/%h want 0", vid_data, mem_addr, mem_wdata);
    end
    reset_n = 1'b1;
    step();
    // Start a draw and a video read, then reset in the middle of the RMW.
    drw_addr = 19'd43; drw_pixel = 3'b101; drw_req = 1'b1;
    step();
    vid_req = 1'b1; vid_word_addr = 16'd3;
    step();
    vid_req = 1'b0;
    total++;
    if (drw_busy !== 1'b1) begin
      bad++; $display("FAIL reset_pre_busy: got %b want 1", drw_busy);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({vid_valid, drw_ack, drw_busy, mem_en, mem_we} !== 5'b0 || mem_addr !== '0) begin
      bad++; $display("FAIL reset_async: flags=%b addr=%h want 0", {vid_valid, drw_ack, drw_busy, mem_en, mem_we}, mem_addr);
    end
    drw_req = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (mem_en !== 1'b0 || drw_ack !== 1'b0 || vid_valid !== 1'b0) begin
        bad++; $display("FAIL reset_quiet: cycle %0d en=%b ack=%b vv=%b want 0", i, mem_en, drw_ack, vid_valid);
      end
    end
  endtask

  task automatic test_vid_read();
    poke(5, 24'hFAC688);
    vid_req = 1'b1; vid_word_addr = 16'd5;
    step();
    vid_req = 1'b0;
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'd5) begin
      bad++; $display("FAIL vid_issue: en=%b we=%b addr=%h want 1/0/5", mem_en, mem_we, mem_addr);
    end
    step();
    total++;
    if (vid_valid !== 1'b0) begin
      bad++; $display("FAIL vid_early: got %b want 0", vid_valid);
    end
    step();
    total++;
    if (vid_valid !== 1'b1 || vid_data !== 24'hFAC688) begin
      bad++; $display("FAIL vid_data: valid=%b data=%h want 1/fac688", vid_valid, vid_data);
    end
    step();
    total++;
    if (vid_valid !== 1'b0) begin
      bad++; $display("FAIL vid_pulse: got %b want 0", vid_valid);
    end
  endtask

  task automatic test_draw();
    poke(5, 24'h000000);
    drw_addr = 19'd43; drw_pixel = 3'b101; drw_req = 1'b1;
    step();
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'd5 || drw_busy !== 1'b1 || drw_ack !== 1'b0) begin
      bad++; $display("FAIL draw_read: en=%b we=%b addr=%h busy=%b ack=%b want 1/0/5/1/0",
                      mem_en, mem_we, mem_addr, drw_busy, drw_ack);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (drw_ack !== 1'b0) begin
        bad++; $display("FAIL draw_ack_early: cycle %0d got %b want 0", i, drw_ack);
      end
    end
    step();
    total++;
    if (drw_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'd5 || mem_wdata !== 24'h000A00 || drw_busy !== 1'b0) begin
      bad++; $display("FAIL draw_write: ack=%b we=%b addr=%h wdata=%h busy=%b want 1/1/5/000a00/0",
                      drw_ack, mem_we, mem_addr, mem_wdata, drw_busy);
    end
    drw_req = 1'b0;
    shadow[5] = 24'h000A00;
    vid_req = 1'b1; vid_word_addr = 16'd5;
    step();
    vid_req = 1'b0;
    step();
    step();
    total++;
    if (vid_valid !== 1'b1 || vid_data !== 24'h000A00) begin
      bad++; $display("FAIL draw_readback: valid=%b data=%h want 1/000a00", vid_valid, vid_data);
    end
  endtask

  task automatic test_draw_vid_conflict();
    logic        p1v, p2v, cv;
    logic [23:0] p1d, p2d, cd;
    int          acks, ack_i;
    poke(6, 24'h123456);
    drw_addr = 19'd49; drw_pixel = 3'b111; drw_req = 1'b1;
    repeat (3) step();
    p1v = 1'b0; p2v = 1'b0; p1d = '0; p2d = '0;
    acks = 0; ack_i = -1;
    for (int i = 0; i < 12; i++) begin
      vid_req = (i < 6);
      vid_word_addr = (i % 2 == 1) ? 16'd5 : 16'd6;
      cv = vid_req;
      cd = shadow[vid_word_addr];
      step();
      if (drw_ack === 1'b1) begin
        acks++; ack_i = i;
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 16'd6 || mem_wdata !== 24'h12347E) begin
          bad++; $display("FAIL conflict_write: we=%b addr=%h wdata=%h want 1/6/12347e", mem_we, mem_addr, mem_wdata);
        end
        drw_req = 1'b0;
        shadow[6] = 24'h12347E;
      end
      total++;
      if (vid_valid !== p2v || (p2v && vid_data !== p2d)) begin
        bad++; $display("FAIL conflict_vid: cycle %0d valid=%b data=%h want %b/%h", i, vid_valid, vid_data, p2v, p2d);
      end
      p2v = p1v; p2d = p1d; p1v = cv; p1d = cd;
    end
    total++;
    if (acks !== 1 || ack_i !== 6) begin
      bad++; $display("FAIL conflict_ack: count=%0d at=%0d want 1 at 6", acks, ack_i);
    end
  endtask

  task automatic test_out_of_range();
    drw_addr = 19'h7FFFF; drw_pixel = 3'b010; drw_req = 1'b1;
    step();
    total++;
    if (drw_ack !== 1'b1 || mem_en !== 1'b0 || drw_busy !== 1'b0) begin
      bad++; $display("FAIL oor_ack: ack=%b en=%b busy=%b want 1/0/0", drw_ack, mem_en, drw_busy);
    end
    drw_req = 1'b0;
    step();
    total++;
    if (drw_ack !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL oor_after: ack=%b we=%b want 0/0", drw_ack, mem_we);
    end
  endtask

  task automatic test_random();
    logic        p1v, p2v, cv, active, oor;
    logic [23:0] p1d, p2d, cd;
    int          wait_cnt, dw, ds, errs;
    logic [2:0]  dp;
    for (int w = 0; w < 16; w++) poke(w, 24'($urandom));
    p1v = 1'b0; p2v = 1'b0; p1d = '0; p2d = '0;
    active = 1'b0; oor = 1'b0; wait_cnt = 0; dw = 0; ds = 0; dp = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      vid_req = (cyc < 1990) && ($urandom_range(0, 99) < 40);
      vid_word_addr = 16'($urandom_range(0, 15));
      if (!active && cyc < 1900 && $urandom_range(0, 9) < 3) begin
        oor = ($urandom_range(0, 7) == 0);
        dw  = oor ? 32'hFE00 + $urandom_range(0, 255) : $urandom_range(0, 15);
        ds  = $urandom_range(0, 7);
        dp  = 3'($urandom_range(0, 7));
        drw_addr = {16'(dw), 3'(ds)}; drw_pixel = dp; drw_req = 1'b1;
        active = 1'b1; wait_cnt = 0;
      end
      cv = vid_req;
      cd = shadow[vid_word_addr];
      step();
      total++;
      if (vid_valid !== p2v || (p2v && vid_data !== p2d)) begin
        bad++; $display("FAIL rand_vid: cycle %0d valid=%b data=%h want %b/%h", cyc, vid_valid, vid_data, p2v, p2d);
      end
      p2v = p1v; p2d = p1d; p1v = cv; p1d = cd;
      total++;
      if (drw_ack === 1'b1 && !active) begin
        bad++; $display("FAIL rand_spurious_ack: cycle %0d ack=1 want 0", cyc);
      end else if (drw_ack === 1'b1) begin
        if (!oor) shadow[dw][ds*3 +: 3] = dp;
        active = 1'b0; drw_req = 1'b0;
      end else if (active) begin
        wait_cnt++;
        if (wait_cnt > 60) begin
          bad++; $display("FAIL rand_ack_timeout: cycle %0d waited %0d want <=60", cyc, wait_cnt);
          active = 1'b0; drw_req = 1'b0;
        end
      end
    end
    errs = 0;
    for (int w = 0; w < 16; w++) if (ram[w] !== shadow[w]) errs++;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL rand_image: %0d words differ want 0", errs);
    end
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    int busy_cycles, errs, guard;
    logic [23:0] exp;
    clr_color = 3'b011; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    total++;
    if (clr_busy !== 1'b1) begin
      bad++; $display("FAIL clr_start: busy=%b want 1", clr_busy);
    end
    drw_addr = 19'd56; drw_pixel = 3'b100; drw_req = 1'b1;
    busy_cycles = 1; guard = 0;
    while (clr_busy === 1'b1 && guard < 50000) begin
      step();
      guard++;
      if (drw_ack === 1'b1) begin
        total++; bad++; $display("FAIL clr_early_ack: ack=1 during clear want 0");
      end
      if (clr_busy === 1'b1) busy_cycles++;
    end
    total++;
    if (busy_cycles < WORDS || guard >= 50000) begin
      bad++; $display("FAIL clr_busy_len: cycles=%0d want >=%0d and finite", busy_cycles, WORDS);
    end
    guard = 0;
    while (drw_ack !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    total++;
    if (drw_ack !== 1'b1) begin
      bad++; $display("FAIL clr_draw_ack: ack=%b want 1 after clear", drw_ack);
    end
    drw_req = 1'b0;
    repeat (3) step();
    errs = 0;
    for (int w = 0; w < WORDS; w++) begin
      exp = (w == 7) ? 24'h6DB6DC : 24'h6DB6DB;
      if (ram[w] !== exp) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL clr_image: %0d words differ want 0", errs);
    end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; vid_req = 1'b0; vid_word_addr = '0;
    drw_req = 1'b0; drw_addr = '0; drw_pixel = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
`ifdef FB_CLEAR_EN
    clr_start = 1'b0; clr_color = '0;
`endif
    test_reset();
    test_vid_read();
    test_draw();
    test_draw_vid_conflict();
    test_out_of_range();
    test_random();
`ifdef FB_CLEAR_EN
    test_clear();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
